// File: rtl/bbox_halt_stage.sv
// Bounding-box stage: R10 triangle -> R11 min/max -> R12 grid snap (+optional clip) -> R13 output.
// Optional screen clipping/culling is compiled in with `define BBOX_SCREEN_CLIP_EN.
module bbox_halt_stage #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]    tri_R10S,
  input  logic [COLORS-1:0][SIGFIG-1:0]             color_R10U,
  input  logic                                      validTri_R10H,
  input  logic [3:0]                                subSample_RnnnnU,
  input  logic [1:0][SIGFIG-1:0]                    screen_RnnnnS,
  input  logic                                      halt_RnnnnL,
  output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]    tri_R13S,
  output logic [COLORS-1:0][SIGFIG-1:0]             color_R13U,
  output logic [1:0][1:0][SIGFIG-1:0]               box_R13S,
  output logic                                      validTri_R13H
);

  typedef logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_t;
  typedef logic [COLORS-1:0][SIGFIG-1:0]          color_t;
  typedef logic [1:0][1:0][SIGFIG-1:0]            box_t;

  tri_t   tri_r11, tri_r12;
  color_t color_r11, color_r12;
  box_t   box_r11, box_r12;
  logic   valid_r11, valid_r12;
  logic   cull_r12;

  box_t              box_mm;
  box_t              box_snap;
  logic              cull_snap;
  logic [SIGFIG-1:0] delta;
  logic [SIGFIG-1:0] mask;

  // Signed per-axis min/max over all vertices, x and y only.
  always_comb begin
    box_mm = '0;
    for (int unsigned a = 0; a < 2; a++) begin
      box_mm[0][a] = tri_R10S[0][a];
      box_mm[1][a] = tri_R10S[0][a];
      for (int unsigned v = 1; v < VERTS; v++) begin
        if ($signed(tri_R10S[v][a]) < $signed(box_mm[0][a]))
          box_mm[0][a] = tri_R10S[v][a];
        if ($signed(tri_R10S[v][a]) > $signed(box_mm[1][a]))
          box_mm[1][a] = tri_R10S[v][a];
      end
    end
  end

`ifdef BBOX_SCREEN_CLIP_EN
  logic [SIGFIG-1:0] lim;
`else
  logic unused_screen;
  assign unused_screen = ^screen_RnnnnS;
`endif

  // Masking floors toward -inf in two's complement, so negatives snap down.
  always_comb begin
    delta     = {{(SIGFIG-4){1'b0}}, subSample_RnnnnU} << (RADIX-3);
    mask      = ~(delta - SIGFIG'(1));
    box_snap  = '0;
    cull_snap = 1'b0;
`ifdef BBOX_SCREEN_CLIP_EN
    lim       = '0;
`endif
    for (int unsigned a = 0; a < 2; a++) begin
      box_snap[0][a] = box_r11[0][a] & mask;
      box_snap[1][a] = box_r11[1][a] & mask;
`ifdef BBOX_SCREEN_CLIP_EN
      lim = screen_RnnnnS[a] - delta;
      if ($signed(box_snap[0][a]) < 0)
        box_snap[0][a] = '0;
      if ($signed(box_snap[1][a]) > $signed(lim))
        box_snap[1][a] = lim;
      if ($signed(box_snap[1][a]) < $signed(box_snap[0][a]))
        cull_snap = 1'b1;
`endif
    end
  end

  // One shared enable: low halt freezes every stage, valids included.
  always_ff @(posedge clk) begin
    if (rst) begin
      tri_r11       <= '0;
      color_r11     <= '0;
      box_r11       <= '0;
      valid_r11     <= 1'b0;
      tri_r12       <= '0;
      color_r12     <= '0;
      box_r12       <= '0;
      valid_r12     <= 1'b0;
      cull_r12      <= 1'b0;
      tri_R13S      <= '0;
      color_R13U    <= '0;
      box_R13S      <= '0;
      validTri_R13H <= 1'b0;
    end else if (halt_RnnnnL) begin
      tri_r11       <= tri_R10S;
      color_r11     <= color_R10U;
      box_r11       <= box_mm;
      valid_r11     <= validTri_R10H;
      tri_r12       <= tri_r11;
      color_r12     <= color_r11;
      box_r12       <= box_snap;
      valid_r12     <= valid_r11;
      cull_r12      <= cull_snap;
      tri_R13S      <= tri_r12;
      color_R13U    <= color_r12;
      box_R13S      <= box_r12;
      validTri_R13H <= valid_r12 & ~cull_r12;
    end
  end

endmodule
